// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU data-memory port.
// Accepts one load/store at a time over a valid/ready handshake, waits
// WAIT_CYCLES, commits the access to a word-organised RAM and holds the
// response until the requester consumes it.
// Build option: define DMEM_ERR_CHECK_EN to flag misaligned, reserved-size
// and out-of-range accesses. Without it, accesses are forced aligned, the
// word index wraps and size 3 behaves as a word access.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    logic        q_we;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [1:0]  q_size;
    logic        q_unsigned;

    logic [31:0] mem [DEPTH_WORDS];

    // Access fields seen by the commit logic.
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_unsigned;

    logic        accept;
    logic        commit;
    logic [29:0] word_full;
    logic [AW-1:0] idx;
    logic [1:0]  off;
    logic        a_err;
    logic [3:0]  wr_mask;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic [31:0] rsp_next;

    assign req_ready = reset && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;

    // The access commits on the edge that enters RESP: straight from IDLE
    // when there are no wait states, otherwise on the last WAIT cycle.
    assign commit = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (wait_cnt == 4'd1));

    // Select live request fields when committing from IDLE, else the latched copy.
    always_comb begin
        // NOTE: each combinational output is given a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        a_we       = q_we;
        a_addr     = q_addr;
        a_wdata    = q_wdata;
        a_size     = q_size;
        a_unsigned = q_unsigned;
        if (state == S_IDLE) begin
            a_we       = req_we;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
            a_size     = req_size;
            a_unsigned = req_unsigned;
        end
    end

    // Decode lane, word index, error and the load/store data paths.
    always_comb begin
        word_full = a_addr[31:2];
        idx       = AW'(word_full % 30'(DEPTH_WORDS));
        wr_mask   = 4'b1111;
        wr_word   = a_wdata;
        off       = 2'd0;
        case (a_size)
            2'd0: begin
                off     = a_addr[1:0];
                wr_mask = 4'b0001 << a_addr[1:0];
                wr_word = {4{a_wdata[7:0]}};
            end
            2'd1: begin
                off     = {a_addr[1], 1'b0};
                wr_mask = a_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{a_wdata[15:0]}};
            end
            default: begin
                off     = 2'd0;
                wr_mask = 4'b1111;
                wr_word = a_wdata;
            end
        endcase

`ifdef DMEM_ERR_CHECK_EN
        a_err = (a_size == 2'd3) ||
                ((a_size == 2'd1) && a_addr[0]) ||
                ((a_size == 2'd2) && (a_addr[1:0] != 2'd0)) ||
                ({2'b00, word_full} >= 32'(DEPTH_WORDS));
`else
        a_err = 1'b0;
`endif

        rd_word  = mem[idx];
        rd_shift = rd_word >> {off, 3'b000};
        case (a_size)
            2'd0:    rd_ext = a_unsigned ? {24'h0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = a_unsigned ? {16'h0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase
        rsp_next = (a_err || a_we) ? 32'h0 : rd_ext;
    end

    // Handshake FSM: latch the request, count wait states, hold the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            q_we       <= 1'b0;
            q_addr     <= 32'h0;
            q_wdata    <= 32'h0;
            q_size     <= 2'd0;
            q_unsigned <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        q_we       <= req_we;
                        q_addr     <= req_addr;
                        q_wdata    <= req_wdata;
                        q_size     <= req_size;
                        q_unsigned <= req_unsigned;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                rsp_rdata <= rsp_next;
                rsp_err   <= a_err;
            end
        end
    end

    // Write only the addressed byte lanes of the word on commit.
    // NOTE: the RAM array is deliberately not reset; its contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && a_we && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a byte-level memory model predicts every
// response of the WAIT_CYCLES=1 instance each cycle; directed vectors with
// literal expectations exercise lanes, extension, back-pressure, reset and
// errors; a second WAIT_CYCLES=0 instance checks latency and throughput.
module tb_data_mem_responder;

    localparam int DEPTH  = 64;
    localparam int W      = 1;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_z, req_ready_z, req_we_z, req_unsigned_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [1:0]  req_size_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_size(req_size_z),
        .req_unsigned(req_unsigned_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mmem [int];
    bit          pend = 1'b0;
    bit          resolved = 1'b0;
    int          due = 0;
    int          cyc = 0;
    logic        p_we, p_uns;
    logic [31:0] p_addr, p_wdata;
    logic [1:0]  p_size;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err = 1'b0;

    task automatic model_resolve();
        int nb;
        int base;
        logic [31:0] a;
        logic [31:0] v;
        nb = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
`ifdef DMEM_ERR_CHECK_EN
        m_err = (p_size == 2'd3) || ((p_addr % nb) != 0) || ((p_addr >> 2) >= DEPTH);
        a = p_addr;
`else
        m_err = 1'b0;
        a = p_addr - (p_addr % nb);
`endif
        base = int'(((a >> 2) % DEPTH) * 4 + (a % 4));
        if (m_err) begin
            m_rdata = 32'h0;
        end else if (p_we) begin
            for (int i = 0; i < nb; i++) mmem[base + i] = p_wdata[8*i +: 8];
            m_rdata = 32'h0;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(mmem[base + i]) << (8 * i));
            if (!p_uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            m_rdata = v;
        end
        resolved = 1'b1;
    endtask

    // Track accepted requests and consumed responses on each rising edge.
    always @(posedge clk) begin : model_edge
        bit was_pend;
        was_pend = pend;
        if (reset) begin
            if (pend && cyc >= due && rsp_ready) pend = 1'b0;
            if (!was_pend && req_valid) begin
                pend     = 1'b1;
                due      = cyc + 1 + W;
                resolved = 1'b0;
                p_we     = req_we;
                p_addr   = req_addr;
                p_wdata  = req_wdata;
                p_size   = req_size;
                p_uns    = req_unsigned;
            end
        end
        cyc++;
    end

    // A reset drops any transaction in flight.
    always @(negedge reset) pend = 1'b0;

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin : compare
        bit exp_v;
        if (!reset) begin
            check("rst_req_ready", {31'h0, req_ready}, 32'h0);
            check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end else begin
            exp_v = pend && (cyc >= due);
            if (exp_v && !resolved) model_resolve();
            check("req_ready", {31'h0, req_ready}, {31'h0, !pend});
            check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_v});
            if (exp_v) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        req_unsigned = uns; req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            note_timeout("txn_accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; lat++; end
        if (!rsp_valid) begin
            note_timeout("txn_response");
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
    endtask

    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic er;
        int lat;
        txn(we, addr, wdata, size, uns, rd, er, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, {31'h0, er}, {31'h0, exp_er});
        check({name, "_latency"}, 32'(lat), 32'(W + 1));
        check({name, "_model"}, m_rdata, exp_rd);
    endtask

    task automatic wait_rsp_valid(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!rsp_valid) note_timeout(name);
    endtask

    initial begin
        int n;
        int done;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b1;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = 32'h0; req_wdata_z = 32'h0;
        req_size_z = 2'd0; req_unsigned_z = 1'b0; rsp_ready_z = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("reset_req_ready_z", {31'h0, req_ready_z}, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check("release_req_ready", {31'h0, req_ready}, 32'h1);

        // Word store/load, then byte lane merge and extension.
        access("st_word_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0);
        access("ld_word_10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        access("st_byte_13", 1'b1, 32'h13, 32'h0000005A, 2'd0, 1'b0, 32'h0, 1'b0);
        access("ld_word_merge", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h5AADBEEF, 1'b0);
        access("ld_byte_s_11", 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 32'hFFFFFFBE, 1'b0);
        access("ld_half_u_12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 32'h00005AAD, 1'b0);
        access("ld_half_s_12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 32'h00005AAD, 1'b0);
        access("st_half_16", 1'b1, 32'h16, 32'hFFFF8001, 2'd1, 1'b0, 32'h0, 1'b0);
        access("ld_half_s_16", 1'b0, 32'h16, 32'h0, 2'd1, 1'b0, 32'hFFFF8001, 1'b0);
        access("ld_byte_u_10", 1'b0, 32'h10, 32'h0, 2'd0, 1'b1, 32'h000000EF, 1'b0);

        // Back-pressure: response held for 5 cycles while a second request waits.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_addr = 32'h13; req_size = 2'd0; req_unsigned = 1'b1;
        @(negedge clk);
        wait_rsp_valid("hold_first_rsp");
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold_rsp_rdata", rsp_rdata, 32'h5AADBEEF);
            check("hold_req_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_hold_req_ready", {31'h0, req_ready}, 32'h1);
        check("after_hold_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        wait_rsp_valid("hold_second_rsp");
        check("second_rsp_rdata", rsp_rdata, 32'h0000005A);
        @(posedge clk);

`ifdef DMEM_ERR_CHECK_EN
        access("st_word_20", 1'b1, 32'h20, 32'h0BADF00D, 2'd2, 1'b0, 32'h0, 1'b0);
        access("st_misaligned_22", 1'b1, 32'h22, 32'h12345678, 2'd2, 1'b0, 32'h0, 1'b1);
        access("ld_word_20_kept", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1'b0);
        access("ld_out_of_range", 1'b0, 32'(DEPTH * 4), 32'h0, 2'd2, 1'b0, 32'h0, 1'b1);
        access("ld_size3", 1'b0, 32'h20, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);
        access("ld_half_odd", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
`else
        access("st_word_20", 1'b1, 32'h20, 32'h0BADF00D, 2'd2, 1'b0, 32'h0, 1'b0);
        access("st_forced_22", 1'b1, 32'h22, 32'h12345678, 2'd2, 1'b0, 32'h0, 1'b0);
        access("ld_word_20_new", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b0);
        access("ld_wrapped", 1'b0, 32'(DEPTH * 4 + 16), 32'h0, 2'd2, 1'b0, 32'h5AADBEEF, 1'b0);
        access("ld_size3_word", 1'b0, 32'h20, 32'h0, 2'd3, 1'b0, 32'h12345678, 1'b0);
        access("st_half_33", 1'b1, 32'h33, 32'h0000BEEF, 2'd1, 1'b0, 32'h0, 1'b0);
        access("ld_half_u_32", 1'b0, 32'h32, 32'h0, 2'd1, 1'b1, 32'h0000BEEF, 1'b0);
`endif

        // Reset during WAIT drops an uncommitted store.
        access("st_word_40", 1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h11111111; req_size = 2'd2;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_wait_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_wait_req_ready", {31'h0, req_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check("rst_wait_release_ready", {31'h0, req_ready}, 32'h1);
        access("ld_word_40_prior", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);

        // Reset while a committed response is held drops rsp_valid at once.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h22222222; req_size = 2'd2;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        wait_rsp_valid("rst_resp_wait");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_resp_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_resp_rsp_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        rsp_ready = 1'b1;
        access("ld_word_44", 1'b0, 32'h44, 32'h0, 2'd2, 1'b0, 32'h22222222, 1'b0);

        // Zero wait states: ten back-to-back stores take 20 cycles.
        @(negedge clk);
        req_we_z = 1'b1; req_addr_z = 32'h8; req_size_z = 2'd2; req_unsigned_z = 1'b0;
        req_wdata_z = 32'h0; req_valid_z = 1'b1; rsp_ready_z = 1'b1;
        n = 0;
        done = 0;
        while (done < 10 && n < 100) begin
            if (n == 1) check("z_first_latency", {31'h0, rsp_valid_z}, 32'h1);
            if (rsp_valid_z) done++;
            @(posedge clk);
            n++;
            #1 req_wdata_z = 32'(n);
            if (done == 10) req_valid_z = 1'b0;
            @(negedge clk);
        end
        req_valid_z = 1'b0;
        check("z_ten_txn_cycles", 32'(n), 32'd20);
        check("z_idle_after_burst", {31'h0, req_ready_z}, 32'h1);
        req_we_z = 1'b0;
        req_valid_z = 1'b1;
        @(posedge clk);
        #1 req_valid_z = 1'b0;
        @(negedge clk);
        check("z_load_rsp_valid", {31'h0, rsp_valid_z}, 32'h1);
        check("z_load_rdata", rsp_rdata_z, 32'd18);
        check("z_load_err", {31'h0, rsp_err_z}, 32'h0);
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
